// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FSM state encoding.
// Defining UART_RX_PARITY_EN widens the state to 3 bits and adds PARITY.
package uart_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;
    localparam int OVS_DEF     = 16;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        STOP   = 3'b011,
        PARITY = 3'b100
    } rx_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } rx_state_e;
`endif

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take on reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start/data/stop deserializer.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF,
    parameter int OVS     = OVS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
`ifdef UART_RX_PARITY_EN
    input  logic            par_odd,
    output logic            parity_err,
`endif
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    localparam int SW = $clog2(max_int(OVS, SB_TICK));
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] MID_CNT  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] BIT_END  = SW'(OVS - 1);
    localparam logic [SW-1:0] STOP_END = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(DBIT - 1);

    logic rx_s;

    rx_state_e       state_q, state_d;
    logic [SW-1:0]   s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_cnt_q, n_cnt_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_bit_q, par_bit_d;
    logic            perr_q, perr_d;
`endif

    // Line idles high, so the synchronizer must not fake a start bit out of reset.
    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            n_cnt_q   <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_cnt_q   <= n_cnt_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    // Result registers change only on frame completion, so done_q lines up with new dout/flags.
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        n_cnt_d   = n_cnt_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = ferr_q;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == MID_CNT) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_END) begin
                        s_cnt_d = '0;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_cnt_d = n_cnt_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_cnt_q == BIT_END) begin
                        par_bit_d = rx_s;
                        s_cnt_d   = '0;
                        state_d   = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == STOP_END) begin
                        dout_d  = shift_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_bit_q ^ (^shift_q) ^ par_odd;
`endif
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign busy         = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: s_tick every 4 clk, one bit = 64 clk.
// Define UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_rx_ctrl;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       par_odd = 1'b0;
    logic       parity_err;
    logic       parFlip = 1'b0;
    logic       lastPerr = 1'b0;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int strobeCount = 0;
    int cycleCount = 0;
    int tickCnt = 0;
    logic [7:0] lastDout = '0;
    logic lastFerr = 1'b0;
    logic lastBusy = 1'b0;
    logic prevDone = 1'b0;
    int strobeCycles[$];
    logic [7:0] doutHist[$];

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic [7:0] expDout;
        logic       expFerr;
    } rxVec_t;

    rxVec_t vecs[4];

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
`ifdef UART_RX_PARITY_EN
        .par_odd      (par_odd),
        .parity_err   (parity_err),
`endif
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Rate generator model with M=4.
    always @(negedge clk) begin
        tickCnt = (tickCnt + 1) % 4;
        s_tick = (tickCnt == 0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Captures every strobe and the outputs that accompany it.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            checkOutput("doneSingleCycle", 32'(prevDone), 32'd0);
            strobeCount++;
            lastDout = dout;
            lastFerr = frame_err;
            lastBusy = busy;
`ifdef UART_RX_PARITY_EN
            lastPerr = parity_err;
`endif
            strobeCycles.push_back(cycleCount);
            doutHist.push_back(dout);
        end
        prevDone = rx_done_tick;
    end

    // A bad stop bit is held low only through the sample point so the line
    // is back high well before any re-armed start detection samples it.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^data) ^ parFlip;
        repeat (BIT_CLKS) @(negedge clk);
`endif
        rx = stopBit;
        if (stopBit) begin
            repeat (BIT_CLKS) @(negedge clk);
        end else begin
            repeat (48) @(negedge clk);
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int idx0;

        vecs[0] = '{data: 8'hA5, stopBit: 1'b1, expDout: 8'hA5, expFerr: 1'b0};
        vecs[1] = '{data: 8'h3C, stopBit: 1'b0, expDout: 8'h3C, expFerr: 1'b1};
        vecs[2] = '{data: 8'h00, stopBit: 1'b1, expDout: 8'h00, expFerr: 1'b0};
        vecs[3] = '{data: 8'hC3, stopBit: 1'b1, expDout: 8'hC3, expFerr: 1'b0};

        repeat (4) @(negedge clk);
        checkOutput("resetDone", 32'(rx_done_tick), 32'd0);
        checkOutput("resetDout", 32'(dout), 32'd0);
        checkOutput("resetFerr", 32'(frame_err), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (16) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            c0 = strobeCount;
            applyStimulus(vecs[v].data, vecs[v].stopBit);
            repeat (64) @(negedge clk);
            checkOutput("vecStrobeCount", 32'(strobeCount), 32'(c0 + 1));
            checkOutput("vecDout", 32'(lastDout), 32'(vecs[v].expDout));
            checkOutput("vecFerr", 32'(lastFerr), 32'(vecs[v].expFerr));
            checkOutput("vecBusyAfterStrobe", 32'(lastBusy), 32'd0);
        end

        // Glitch shorter than half a bit must be rejected silently.
        c0 = strobeCount;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (96) @(negedge clk);
        checkOutput("glitchNoStrobe", 32'(strobeCount), 32'(c0));
        checkOutput("glitchDout", 32'(dout), 32'hC3);
        checkOutput("glitchFerr", 32'(frame_err), 32'd0);
        checkOutput("glitchBusy", 32'(busy), 32'd0);

        c0 = strobeCount;
        idx0 = strobeCycles.size();
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h81, 1'b1);
        repeat (64) @(negedge clk);
        checkOutput("b2bStrobeCount", 32'(strobeCount), 32'(c0 + 3));
        if (strobeCycles.size() >= idx0 + 3) begin
            checkOutput("b2bDout0", 32'(doutHist[idx0]), 32'hFF);
            checkOutput("b2bDout1", 32'(doutHist[idx0 + 1]), 32'h00);
            checkOutput("b2bDout2", 32'(doutHist[idx0 + 2]), 32'h81);
            checkOutput("b2bGap01", 32'(strobeCycles[idx0 + 1] - strobeCycles[idx0] >= 640), 32'd1);
            checkOutput("b2bGap12", 32'(strobeCycles[idx0 + 2] - strobeCycles[idx0 + 1] >= 640), 32'd1);
        end

        // Abort 0x55 after its third data bit.
        c0 = strobeCount;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (8'h55 >> i) & 8'h01;
            repeat (BIT_CLKS) @(negedge clk);
        end
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midResetDone", 32'(rx_done_tick), 32'd0);
        checkOutput("midResetDout", 32'(dout), 32'd0);
        checkOutput("midResetFerr", 32'(frame_err), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        repeat (128) @(negedge clk);
        checkOutput("midResetNoStrobe", 32'(strobeCount), 32'(c0));
        applyStimulus(8'h96, 1'b1);
        repeat (64) @(negedge clk);
        checkOutput("afterResetStrobe", 32'(strobeCount), 32'(c0 + 1));
        checkOutput("afterResetDout", 32'(lastDout), 32'h96);
        checkOutput("afterResetFerr", 32'(lastFerr), 32'd0);

`ifdef UART_RX_PARITY_EN
        par_odd = 1'b0;
        parFlip = 1'b0;
        c0 = strobeCount;
        applyStimulus(8'h07, 1'b1);
        repeat (64) @(negedge clk);
        checkOutput("parGoodStrobe", 32'(strobeCount), 32'(c0 + 1));
        checkOutput("parGoodErr", 32'(lastPerr), 32'd0);
        checkOutput("parGoodDout", 32'(lastDout), 32'h07);
        parFlip = 1'b1;
        applyStimulus(8'h07, 1'b1);
        repeat (64) @(negedge clk);
        checkOutput("parBadStrobe", 32'(strobeCount), 32'(c0 + 2));
        checkOutput("parBadErr", 32'(lastPerr), 32'd1);
        checkOutput("parBadFerr", 32'(lastFerr), 32'd0);
        parFlip = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
